muldiv_unit: RTL
================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand and result width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit, single clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit; reset is asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit, request to begin operation op.
REQ-005 The block SHALL have port op, input, 2 bits, operation code: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 The block SHALL have port cancel, input, 1 bit, abort of the in-flight operation (pipeline flush).
REQ-007 The block SHALL have ports rs_data and rt_data, input, WIDTH each, first and second operand.
REQ-008 The block SHALL have port busy, output, 1 bit, high while an operation is in flight.
REQ-009 The block SHALL have ports hi_we and lo_we, output, 1 bit each, write enables to the HI and LO registers.
REQ-010 The block SHALL have ports hi_wdata and lo_wdata, output, WIDTH each, write data to the HI and LO registers.

Function
REQ-011 The FSM SHALL have states IDLE, CALC and DONE.
REQ-012 In IDLE with start=1, the FSM SHALL latch op and operand magnitudes plus sign flags, clear the iteration counter and enter CALC.
REQ-013 CALC SHALL run exactly WIDTH iterations: shift-add for multiply, restoring shift-subtract for divide; it then enters DONE.
REQ-014 DONE SHALL last one cycle with hi_we=lo_we=1, then the FSM returns to IDLE.
REQ-015 With start at cycle 0 (iterative mode), the write pulse SHALL occur at cycle WIDTH+1.
REQ-016 busy SHALL be 1 in CALC and DONE and 0 in IDLE; start SHALL be ignored while busy=1.
REQ-017 For multiply, hi_wdata SHALL carry the upper WIDTH bits and lo_wdata the lower WIDTH bits of the 2*WIDTH-bit product.
REQ-018 For divide, lo_wdata SHALL carry the quotient and hi_wdata the remainder.
REQ-019 Signed operations: product sign = sign(rs)^sign(rt); quotient sign = sign(rs)^sign(rt); remainder sign = sign(rs); sign correction SHALL be applied in DONE.
REQ-020 Divide by zero, signed or unsigned: lo_wdata SHALL be all ones and hi_wdata SHALL equal rs_data; the operation still takes the full latency.
REQ-021 Signed overflow (0x80000000 / -1): lo_wdata SHALL be 0x80000000 and hi_wdata SHALL be 0.
REQ-022 cancel=1 in any state SHALL force IDLE on the next edge with no write pulse; cancel SHALL take priority over start and over DONE.
REQ-023 Outside DONE, hi_we and lo_we SHALL be 0; hi_wdata and lo_wdata SHALL hold their last values.

Reset
REQ-024 When rst=1, the block SHALL asynchronously force: state to IDLE, busy=0, hi_we=lo_we=0, hi_wdata=lo_wdata=0, and counter and internal registers to 0.
REQ-025 Reset asserted mid-operation SHALL discard the operation with no write pulse; the first start after rst deasserts SHALL be accepted normally.

Configuration
REQ-026 With macro MULDIV_FAST_MUL_EN defined, MULT and MULTU SHALL use a single-cycle array multiply (IDLE->DONE, write pulse at cycle 1); without it, multiply SHALL be iterative per REQ-013.
REQ-027 Divide timing SHALL be identical with or without MULDIV_FAST_MUL_EN.

Structure
REQ-028 Package muldiv_pkg SHALL hold the op encoding constants, the FSM state typedef and the iteration-count width constant.
REQ-029 The restoring divider datapath SHALL be sub-module muldiv_div_core (magnitude in, quotient and remainder out, one iteration per cycle).

Verification
REQ-030 Bench: MULT rs=0xFFFFFFFE (-2), rt=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA, write pulse at cycle 33 (cycle 1 with fast multiply).
REQ-031 Bench: MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-032 Bench: DIV rs=-7, rt=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU rs=7, rt=0 -> lo=0xFFFFFFFF, hi=7.
REQ-033 Bench: DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-034 Bench: start at cycle 0, cancel at cycle 10, second start at cycle 5 -> no write pulse ever, busy=0 at cycle 11.
REQ-035 Bench: rst asserted at cycle 15 of a DIVU -> outputs 0 immediately, no pulse; new DIVU 100/7 -> lo=14, hi=2.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings and sizing for the multiply/divide unit.
// Also used by the MULDIV_FAST_MUL_EN build of muldiv_unit.
package muldiv_pkg;

    localparam logic [1:0] OpMult  = 2'b00;
    localparam logic [1:0] OpMultu = 2'b01;
    localparam logic [1:0] OpDiv   = 2'b10;
    localparam logic [1:0] OpDivu  = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_e;

    // Iteration counter is sized for the widest supported operand.
    localparam int unsigned MaxWidth = 64;
    localparam int unsigned CntW     = $clog2(MaxWidth) + 1;

endpackage

// File: rtl/muldiv_div_core.sv
// Restoring divider datapath on unsigned magnitudes, one quotient bit per step.
// Quotient and remainder are valid after WIDTH steps following a load.
module muldiv_div_core #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o
);

    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH:0]   partial;
    logic [WIDTH:0]   trial;

    always_comb begin
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        partial = {rem_q, quo_q[WIDTH-1]};
        trial   = partial - {1'b0, dvs_q};
        if (load_i) begin
            quo_d = dividend_i;
            rem_d = '0;
            dvs_d = divisor_i;
        end else if (step_i) begin
            // Borrow out of bit WIDTH means the trial subtraction went negative: restore.
            if (trial[WIDTH]) begin
                rem_d = partial[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end else begin
                rem_d = trial[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
        end else begin
            quo_q <= quo_d;
            rem_q <= rem_d;
            dvs_q <= dvs_d;
        end
    end

    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit writing HI/LO on a one-cycle DONE pulse.
// Define MULDIV_FAST_MUL_EN for a single-cycle array multiply (divide unchanged).
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             cancel,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic             busy,
    output logic             hi_we,
    output logic             lo_we,
    output logic [WIDTH-1:0] hi_wdata,
    output logic [WIDTH-1:0] lo_wdata
);

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               div_q, div_d;
    logic               rs_neg_q, rs_neg_d;
    logic               rt_neg_q, rt_neg_d;
    logic               dbz_q, dbz_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               is_signed, is_div, res_neg;
    logic [WIDTH-1:0]   rs_mag, rt_mag;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_raw, rem_raw;
    logic [WIDTH-1:0]   hi_res, lo_res;
    logic               div_load, div_step, done_ok;

    muldiv_div_core #(
        .WIDTH (WIDTH)
    ) u_div_core (
        .clk         (clk),
        .rst         (rst),
        .load_i      (div_load),
        .step_i      (div_step),
        .dividend_i  (rs_mag),
        .divisor_i   (rt_mag),
        .quotient_o  (quo_raw),
        .remainder_o (rem_raw)
    );

    always_comb begin
        is_signed = (op == OpMult) || (op == OpDiv);
        is_div    = (op == OpDiv) || (op == OpDivu);
        rs_mag    = (is_signed && rs_data[WIDTH-1]) ? -rs_data : rs_data;
        rt_mag    = (is_signed && rt_data[WIDTH-1]) ? -rt_data : rt_data;
        mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);

        // Sign correction on the magnitude results; MIN / -1 falls out naturally.
        res_neg  = rs_neg_q ^ rt_neg_q;
        prod_fix = res_neg ? -prod_q : prod_q;
        if (div_q) begin
            hi_res = rs_neg_q ? -rem_raw : rem_raw;
            lo_res = dbz_q ? '1 : (res_neg ? -quo_raw : quo_raw);
        end else begin
            hi_res = prod_fix[2*WIDTH-1:WIDTH];
            lo_res = prod_fix[WIDTH-1:0];
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        rs_neg_d = rs_neg_q;
        rt_neg_d = rt_neg_q;
        dbz_d    = dbz_q;
        mcand_d  = mcand_q;
        prod_d   = prod_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        div_load = 1'b0;
        div_step = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    div_d    = is_div;
                    rs_neg_d = is_signed && rs_data[WIDTH-1];
                    rt_neg_d = is_signed && rt_data[WIDTH-1];
                    dbz_d    = (rt_data == '0);
                    mcand_d  = rs_mag;
                    prod_d   = {{WIDTH{1'b0}}, rt_mag};
                    cnt_d    = '0;
                    div_load = 1'b1;
                    state_d  = StCalc;
`ifdef MULDIV_FAST_MUL_EN
                    if (!is_div) begin
                        prod_d  = {{WIDTH{1'b0}}, rs_mag} * {{WIDTH{1'b0}}, rt_mag};
                        state_d = StDone;
                    end
`endif
                end
            end
            StCalc: begin
                cnt_d = cnt_q + CntW'(1);
                if (div_q) begin
                    div_step = 1'b1;
                end else begin
                    prod_d = {mul_sum, prod_q[WIDTH-1:1]};
                end
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                hi_d    = hi_res;
                lo_d    = lo_res;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (cancel) begin
            state_d = StIdle;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            div_q    <= 1'b0;
            rs_neg_q <= 1'b0;
            rt_neg_q <= 1'b0;
            dbz_q    <= 1'b0;
            mcand_q  <= '0;
            prod_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            rs_neg_q <= rs_neg_d;
            rt_neg_q <= rt_neg_d;
            dbz_q    <= dbz_d;
            mcand_q  <= mcand_d;
            prod_q   <= prod_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    // A cancel arriving during DONE suppresses the pulse in that same cycle.
    assign done_ok  = (state_q == StDone) && !cancel;
    assign busy     = (state_q != StIdle);
    assign hi_we    = done_ok;
    assign lo_we    = done_ok;
    assign hi_wdata = done_ok ? hi_res : hi_q;
    assign lo_wdata = done_ok ? lo_res : lo_q;

endmodule
